mmss_bcd_timer: RTL and testbench

//  Upstream stage of the 4-digit seven-segment display path. Generates the MM:SS count as four BCD digits.

---
 rtl/mmss_bcd_timer_pkg.sv | 24 ++
 rtl/mmss_bcd_timer_bcd_digit_counter.sv | 51 +++++
 rtl/mmss_bcd_timer.sv | 165 ++++++++++++++++
 tb/tb_mmss_bcd_timer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmss_bcd_timer_pkg.sv
// rtl/mmss_bcd_timer_pkg.sv - shared state encodings and BCD limits for the MM:SS timer
//
// Purpose: FSM state type, BCD digit limits and the preset clamp helper used
//          by the MM:SS timer top level.
// Ports:   none (package).

package mmss_bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX_UNIT = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  // Saturate an out-of-range preset digit to the largest legal value.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] val, input logic [3:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/mmss_bcd_timer_bcd_digit_counter.sv
// rtl/mmss_bcd_timer_bcd_digit_counter.sv - one modulo-MOD BCD digit with carry/borrow out
//
// Purpose: single decimal digit of the MM:SS chain, counting up or down by one
//          when enabled. Priority: clear > load > en.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (q -> 0)
//   en        in   advance the digit this cycle
//   down      in   1 = decrement, 0 = increment
//   load      in   load q from load_val
//   load_val  in   4-bit preset (already clamped by the caller)
//   clear     in   force q to 0
//   q         out  current digit 0..MOD-1
//   wrap      out  en while at the boundary (MOD-1 going up, 0 going down);
//                  drives the next digit's en

module bcd_digit_counter #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       down,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clear,
  output logic [3:0] q,
  output logic       wrap
);

  localparam logic [3:0] TOP = 4'(MOD - 1);

  assign wrap = en & (down ? (q == 4'd0) : (q == TOP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clear) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      if (down) begin
        q <= (q == 4'd0) ? TOP : q - 4'd1;
      end else begin
        q <= (q == TOP) ? 4'd0 : q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mmss_bcd_timer.sv
// rtl/mmss_bcd_timer.sv - MM:SS BCD stopwatch/countdown timer feeding the 7-segment decoder
//
// Purpose: counts MM:SS as four BCD digits, one step per TICKS_PER_SEC clocks,
//          with run/pause, preset load, up/down mode and countdown expiry.
//          Command priority each cycle: clear > load > stop > start.
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   start, stop, clear, load    1-cycle command pulses
//   count_down                  1 = decrement per second, 0 = increment
//   load_min_tens..load_sec_unit  4-bit BCD presets (clamped to 5/9)
//   minute_tens, minute_unit, second_tens, second_unit  BCD digit outputs
//   running                     1 while in RUN
//   sec_tick                    1-cycle pulse on every counted second
//   done                        1-cycle pulse when a countdown reaches 00:00

module mmss_bcd_timer
  import mmss_bcd_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic       count_down,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_unit,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_unit,
  output logic [3:0] minute_tens,
  output logic [3:0] minute_unit,
  output logic [3:0] second_tens,
  output logic [3:0] second_unit,
  output logic       running,
  output logic       sec_tick,
  output logic       done
);

  localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  timer_state_t  state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;

  logic tick;
  logic load_ok;
  logic expire;
  logic digits_zero;
  logic last_second;
  logic su_wrap, st_wrap, mu_wrap;
  logic mt_wrap_unused;

  // Load is only honoured outside RUN; clear beats it.
  assign load_ok = load & ~clear & (state != ST_RUN);

  // A second elapses on the terminal prescaler cycle while running. A stop in
  // that same cycle still lets the tick land before pausing.
  assign tick = (state == ST_RUN) & (presc == PRESC_LAST) & ~clear;

  assign digits_zero = (minute_tens == 4'd0) & (minute_unit == 4'd0) &
                       (second_tens == 4'd0) & (second_unit == 4'd0);

  // 00:01 is the only value whose decrement lands on 00:00.
  assign last_second = (minute_tens == 4'd0) & (minute_unit == 4'd0) &
                       (second_tens == 4'd0) & (second_unit == 4'd1);

  assign expire = tick & count_down & last_second;

  bcd_digit_counter #(.MOD(10)) u_sec_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tick),
    .down     (count_down),
    .load     (load_ok),
    .load_val (bcd_clamp(load_sec_unit, BCD_MAX_UNIT)),
    .clear    (clear),
    .q        (second_unit),
    .wrap     (su_wrap)
  );

  bcd_digit_counter #(.MOD(6)) u_sec_tens (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (su_wrap),
    .down     (count_down),
    .load     (load_ok),
    .load_val (bcd_clamp(load_sec_tens, BCD_MAX_TENS)),
    .clear    (clear),
    .q        (second_tens),
    .wrap     (st_wrap)
  );

  bcd_digit_counter #(.MOD(10)) u_min_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (st_wrap),
    .down     (count_down),
    .load     (load_ok),
    .load_val (bcd_clamp(load_min_unit, BCD_MAX_UNIT)),
    .clear    (clear),
    .q        (minute_unit),
    .wrap     (mu_wrap)
  );

  // Wrap past 59:59 (or below 00:00) has no consumer.
  bcd_digit_counter #(.MOD(6)) u_min_tens (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mu_wrap),
    .down     (count_down),
    .load     (load_ok),
    .load_val (bcd_clamp(load_min_tens, BCD_MAX_TENS)),
    .clear    (clear),
    .q        (minute_tens),
    .wrap     (mt_wrap_unused)
  );

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else if (load_ok) begin
      state_nxt = ST_IDLE;
    end else if (expire) begin
      state_nxt = ST_EXPIRED;
    end else if (stop && (state == ST_RUN)) begin
      state_nxt = ST_PAUSED;
    end else if (start) begin
      if (state == ST_PAUSED) begin
        state_nxt = ST_RUN;
      end else if ((state == ST_IDLE) && !(count_down && digits_zero)) begin
        state_nxt = ST_RUN;
      end
    end
  end

  // Prescaler only moves in RUN, so PAUSED keeps the partial second.
  always_comb begin
    presc_nxt = presc;
    if (clear || load_ok) begin
      presc_nxt = '0;
    end else if (state == ST_RUN) begin
      presc_nxt = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      presc    <= '0;
      running  <= 1'b0;
      sec_tick <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      running  <= (state_nxt == ST_RUN);
      sec_tick <= tick;
      done     <= expire;
    end
  end

endmodule

// File: tb/tb_mmss_bcd_timer.sv
// tb/tb_mmss_bcd_timer.sv - self-checking bench for mmss_bcd_timer

module tb_mmss_bcd_timer;

  localparam int T       = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, clear, load, count_down;
  logic [3:0] load_min_tens, load_min_unit, load_sec_tens, load_sec_unit;
  logic [3:0] minute_tens, minute_unit, second_tens, second_unit;
  logic       running, sec_tick, done;

  int checks = 0;
  int errors = 0;

  int m_st, m_sec, m_pre;
  bit m_tick, m_done;

  typedef struct {
    bit          st, sp, cl, ld, cd;
    logic [15:0] lv;
    logic [15:0] ed;
    bit          er, et, edn;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  mmss_bcd_timer #(.TICKS_PER_SEC(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .clear         (clear),
    .load          (load),
    .count_down    (count_down),
    .load_min_tens (load_min_tens),
    .load_min_unit (load_min_unit),
    .load_sec_tens (load_sec_tens),
    .load_sec_unit (load_sec_unit),
    .minute_tens   (minute_tens),
    .minute_unit   (minute_unit),
    .second_tens   (second_tens),
    .second_unit   (second_unit),
    .running       (running),
    .sec_tick      (sec_tick),
    .done          (done)
  );

  function automatic int to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10);
  endfunction

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [15:0] dut_digits();
    return {minute_tens, minute_unit, second_tens, second_unit};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = M_IDLE;
    m_sec  = 0;
    m_pre  = 0;
    m_tick = 0;
    m_done = 0;
  endtask

  // Behavioural reference: time held as whole seconds, prescaler as an int.
  task automatic model_step(input bit st, sp, cl, ld, cd, input logic [15:0] lv);
    m_tick = 0;
    m_done = 0;
    if (cl) begin
      m_st = M_IDLE; m_sec = 0; m_pre = 0;
    end else if (ld && m_st != M_RUN) begin
      m_sec = (clampi(lv[15:12], 5) * 10 + clampi(lv[11:8], 9)) * 60 +
              clampi(lv[7:4], 5) * 10 + clampi(lv[3:0], 9);
      m_pre = 0;
      m_st  = M_IDLE;
    end else begin
      if (m_st == M_RUN) begin
        if (m_pre == T - 1) begin
          m_pre  = 0;
          m_tick = 1;
          if (cd) begin
            m_sec = (m_sec + 3599) % 3600;
            if (m_sec == 0) m_done = 1;
          end else begin
            m_sec = (m_sec + 1) % 3600;
          end
        end else begin
          m_pre++;
        end
      end
      if (m_done) m_st = M_EXP;
      else if (sp && m_st == M_RUN) m_st = M_PAUSE;
      else if (st && (m_st == M_PAUSE || (m_st == M_IDLE && !(cd && m_sec == 0)))) m_st = M_RUN;
    end
  endtask

  // Drive one cycle of inputs, clock, and compare every output to the model.
  task automatic step(input bit st, sp, cl, ld, cd, input logic [15:0] lv);
    start = st; stop = sp; clear = cl; load = ld; count_down = cd;
    {load_min_tens, load_min_unit, load_sec_tens, load_sec_unit} = lv;
    model_step(st, sp, cl, ld, cd, lv);
    @(posedge clk);
    #1;
    start = 0; stop = 0; clear = 0; load = 0;
    check("model", {13'b0, dut_digits(), running, sec_tick, done},
          {13'b0, 16'(to_bcd(m_sec)), (m_st == M_RUN), m_tick, m_done});
  endtask

  task automatic idle(input int n, input bit cd);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, cd, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] lv;
    bit          cd_r;

    rst_n = 0; start = 0; stop = 0; clear = 0; load = 0; count_down = 0;
    {load_min_tens, load_min_unit, load_sec_tens, load_sec_unit} = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_digits", {16'b0, dut_digits()}, 32'h0);
    check("reset_flags", {29'b0, running, sec_tick, done}, 32'h0);
    rst_n = 1;

    // Up ripple, clamp and command priority, up wrap.
    vq.push_back('{0,0,0,1,0,16'h0058,16'h0058,0,0,0});
    vq.push_back('{1,0,0,0,0,16'h0000,16'h0058,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0058,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0058,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0058,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0059,1,1,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0059,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0059,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0059,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0100,1,1,0});
    vq.push_back('{0,1,0,0,0,16'h0000,16'h0100,0,0,0});
    vq.push_back('{0,0,0,1,0,16'h7C9F,16'h5959,0,0,0});
    vq.push_back('{1,0,0,0,0,16'h0000,16'h5959,1,0,0});
    vq.push_back('{0,0,0,1,0,16'h1234,16'h5959,1,0,0});
    vq.push_back('{1,1,0,0,0,16'h0000,16'h5959,0,0,0});
    vq.push_back('{0,0,1,1,0,16'h1234,16'h0000,0,0,0});
    vq.push_back('{1,0,0,0,0,16'h0000,16'h0000,1,0,0});
    vq.push_back('{0,1,0,0,0,16'h0000,16'h0000,0,0,0});
    vq.push_back('{0,0,0,1,0,16'h5959,16'h5959,0,0,0});
    vq.push_back('{1,0,0,0,0,16'h0000,16'h5959,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h5959,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h5959,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h5959,1,0,0});
    vq.push_back('{0,0,0,0,0,16'h0000,16'h0000,1,1,0});
    vq.push_back('{0,0,1,0,0,16'h0000,16'h0000,0,0,0});
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].st, vq[i].sp, vq[i].cl, vq[i].ld, vq[i].cd, vq[i].lv);
      check($sformatf("tbl%0d_digits", i), {16'b0, dut_digits()}, {16'b0, vq[i].ed});
      check($sformatf("tbl%0d_flags", i), {29'b0, running, sec_tick, done},
            {29'b0, vq[i].er, vq[i].et, vq[i].edn});
    end

    // Countdown from 01:01 to expiry.
    step(0, 0, 0, 1, 1, 16'h0101);
    step(1, 0, 0, 0, 1, 16'h0);
    check("down_started", {31'b0, running}, 32'd1);
    for (int k = 1; k <= 61; k++) begin
      idle(T, 1);
      check($sformatf("down_digits_%0d", k), {16'b0, dut_digits()}, to_bcd(61 - k));
      check($sformatf("down_tick_%0d", k), {31'b0, sec_tick}, 32'd1);
    end
    check("expire_flags", {29'b0, running, sec_tick, done}, 32'b011);
    step(0, 0, 0, 0, 1, 16'h0);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    idle(20, 1);
    check("expired_hold", {15'b0, dut_digits(), running}, 32'h0);
    step(1, 0, 0, 0, 1, 16'h0);
    check("expired_start_ignored", {15'b0, dut_digits(), running}, 32'h0);

    // Pause / resume keeps the partial second.
    step(0, 0, 1, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    idle(1, 0);
    step(0, 1, 0, 0, 0, 16'h0);
    check("paused", {31'b0, running}, 32'd0);
    idle(10, 0);
    check("pause_hold", {15'b0, dut_digits(), running}, 32'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    check("resumed", {31'b0, running}, 32'd1);
    idle(1, 0);
    check("resume_no_tick_yet", {15'b0, dut_digits(), sec_tick}, 32'h0);
    idle(1, 0);
    check("resume_tick", {15'b0, dut_digits(), sec_tick}, {15'b0, 16'h0001, 1'b1});

    // Asynchronous reset mid-run while a tick pulse is showing.
    step(0, 0, 1, 0, 0, 16'h0);
    step(0, 0, 0, 1, 0, 16'h1234);
    step(1, 0, 0, 0, 0, 16'h0);
    idle(T, 0);
    check("pre_reset", {13'b0, dut_digits(), running, sec_tick, done}, {13'b0, 16'h1235, 3'b110});
    #2;
    rst_n = 0;
    #1;
    check("async_reset", {13'b0, dut_digits(), running, sec_tick, done}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    idle(8, 0);
    check("post_reset_idle", {15'b0, dut_digits(), running}, 32'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    check("post_reset_start", {31'b0, running}, 32'd1);

    // Randomized commands against the reference model.
    cd_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cd_r = ~cd_r;
      lv = 16'($urandom);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, cd_r, lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
